id_ex_skid_reg: RTL and testbench

ID_EX_SKID_REG -- requirements
Module: id_ex_skid_reg

---
 rtl/id_ex_skid_reg_pkg.sv | 26 ++
 rtl/id_ex_skid_reg_sat_counter.sv | 34 +++
 rtl/id_ex_skid_reg.sv | 133 +++++++++++++
 tb/tb_id_ex_skid_reg.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_skid_reg_pkg.sv
// -----------------------------------------------------------------------------
// id_ex_skid_reg_pkg
// Shared definitions for the pipeline-stage skid registers.
//   - skid_state_e : buffer occupancy state (EMPTY=0, BUSY=1, FULL=2)
//   - FUNC3_W / FUNC7_W / OPCODE_W : fixed instruction field widths
//   - bundle_width() : total packed width of a decode bundle
// -----------------------------------------------------------------------------
package id_ex_skid_reg_pkg;

   localparam int unsigned FUNC3_W  = 3;
   localparam int unsigned FUNC7_W  = 7;
   localparam int unsigned OPCODE_W = 7;

   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StBusy  = 2'd1,
      StFull  = 2'd2
   } skid_state_e;

   // Packed bundle layout (MSB..LSB): reg1, reg2, wr_reg, func3, func7, opcode, imm.
   function automatic int unsigned bundle_width(input int unsigned imm_w,
                                                input int unsigned reg_aw);
      return (3 * reg_aw) + FUNC3_W + FUNC7_W + OPCODE_W + imm_w;
   endfunction

endpackage

// File: rtl/id_ex_skid_reg_sat_counter.sv
// -----------------------------------------------------------------------------
// id_ex_skid_reg_sat_counter
// Up-counter that sticks at its all-ones value instead of wrapping.
// Ports:
//   clk     in   clock, counts on rising edge
//   rst_n   in   asynchronous active-low reset, clears the count
//   i_inc   in   add one this cycle (ignored once saturated)
//   o_count out  current count
// -----------------------------------------------------------------------------
module id_ex_skid_reg_sat_counter #(
   parameter int unsigned Width = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_inc,
   output logic [Width-1:0] o_count
);

   logic [Width-1:0] r_count;
   logic             w_at_max;

   assign w_at_max = &r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_inc && !w_at_max) begin
         r_count <= r_count + Width'(1);
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/id_ex_skid_reg.sv
// -----------------------------------------------------------------------------
// id_ex_skid_reg
// ID/EX pipeline register built as a 2-entry skid buffer. The main register
// drives the outputs; the skid register catches one extra bundle when the
// consumer stalls, so in_ready can be a pure function of state.
// Ports:
//   clk, rst_n                 clock / asynchronous active-low reset
//   in_valid, in_ready         upstream handshake (in_ready registered)
//   r_reg1, r_reg2, wr_reg,
//   func3, func7, opcode,
//   immediate_data             incoming decode bundle
//   flush                      synchronous kill of all buffered bundles
//   out_valid, out_ready       downstream handshake
//   *_out                      registered bundle towards execute
//   stall_cnt                  saturating count of stalled output cycles
// -----------------------------------------------------------------------------
module id_ex_skid_reg
   import id_ex_skid_reg_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned REG_AW = 5,
   parameter int unsigned CNT_W  = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [REG_AW-1:0]   r_reg1,
   input  logic [REG_AW-1:0]   r_reg2,
   input  logic [REG_AW-1:0]   wr_reg,
   input  logic [FUNC3_W-1:0]  func3,
   input  logic [FUNC7_W-1:0]  func7,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic [WIDTH-1:0]    immediate_data,
   input  logic                flush,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [REG_AW-1:0]   r_reg1_out,
   output logic [REG_AW-1:0]   r_reg2_out,
   output logic [REG_AW-1:0]   wr_reg_out,
   output logic [FUNC3_W-1:0]  func3_out,
   output logic [FUNC7_W-1:0]  func7_out,
   output logic [OPCODE_W-1:0] opcode_out,
   output logic [WIDTH-1:0]    immediate_data_out,
   output logic [CNT_W-1:0]    stall_cnt
);

   localparam int unsigned BundleW = bundle_width(WIDTH, REG_AW);

   skid_state_e        r_state;
   logic [BundleW-1:0] r_main;
   logic [BundleW-1:0] r_skid;
   logic               r_in_ready;
   logic               r_out_valid;

   logic [BundleW-1:0] w_in_bundle;
   logic               w_in_xfer;
   logic               w_out_xfer;
   logic               w_stall;

   assign w_in_bundle = {r_reg1, r_reg2, wr_reg, func3, func7, opcode, immediate_data};
   assign w_in_xfer   = in_valid & r_in_ready;
   assign w_out_xfer  = r_out_valid & out_ready;
   assign w_stall     = r_out_valid & ~out_ready;

   // Handshake outputs are registered alongside the state so neither has a
   // combinational path from the opposite side of the buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= StEmpty;
         r_main      <= '0;
         r_skid      <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else if (flush) begin
         // Kill everything buffered; data registers are left untouched.
         r_state     <= StEmpty;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            StEmpty: begin
               if (w_in_xfer) begin
                  r_main      <= w_in_bundle;
                  r_state     <= StBusy;
                  r_out_valid <= 1'b1;
               end
            end
            StBusy: begin
               if (w_in_xfer && w_out_xfer) begin
                  r_main <= w_in_bundle;
               end else if (w_in_xfer) begin
                  r_skid     <= w_in_bundle;
                  r_state    <= StFull;
                  r_in_ready <= 1'b0;
               end else if (w_out_xfer) begin
                  r_state     <= StEmpty;
                  r_out_valid <= 1'b0;
               end
            end
            StFull: begin
               if (w_out_xfer) begin
                  r_main     <= r_skid;
                  r_state    <= StBusy;
                  r_in_ready <= 1'b1;
               end
            end
            default: begin
               r_state     <= StEmpty;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;

   assign {r_reg1_out, r_reg2_out, wr_reg_out, func3_out, func7_out, opcode_out,
           immediate_data_out} = r_main;

   // Counts stalls independent of flush; only reset clears it.
   id_ex_skid_reg_sat_counter #(
      .Width (CNT_W)
   ) u_stall_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_inc   (w_stall),
      .o_count (stall_cnt)
   );

endmodule

// File: tb/tb_id_ex_skid_reg.sv
module tb_id_ex_skid_reg;

   localparam int W  = 8;
   localparam int AW = 5;
   localparam int CW = 4;
   localparam int BW = 3 * AW + 3 + 7 + 7 + W;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [AW-1:0] r_reg1 = '0, r_reg2 = '0, wr_reg = '0;
   logic [2:0]    func3 = '0;
   logic [6:0]    func7 = '0;
   logic [6:0]    opcode = '0;
   logic [W-1:0]  immediate_data = '0;
   logic          flush = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [AW-1:0] r_reg1_out, r_reg2_out, wr_reg_out;
   logic [2:0]    func3_out;
   logic [6:0]    func7_out;
   logic [6:0]    opcode_out;
   logic [W-1:0]  immediate_data_out;
   logic [CW-1:0] stall_cnt;

   always #5 clk = ~clk;

   id_ex_skid_reg #(
      .WIDTH  (W),
      .REG_AW (AW),
      .CNT_W  (CW)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .in_valid           (in_valid),
      .in_ready           (in_ready),
      .r_reg1             (r_reg1),
      .r_reg2             (r_reg2),
      .wr_reg             (wr_reg),
      .func3              (func3),
      .func7              (func7),
      .opcode             (opcode),
      .immediate_data     (immediate_data),
      .flush              (flush),
      .out_valid          (out_valid),
      .out_ready          (out_ready),
      .r_reg1_out         (r_reg1_out),
      .r_reg2_out         (r_reg2_out),
      .wr_reg_out         (wr_reg_out),
      .func3_out          (func3_out),
      .func7_out          (func7_out),
      .opcode_out         (opcode_out),
      .immediate_data_out (immediate_data_out),
      .stall_cnt          (stall_cnt)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: an in-order queue of accepted bundles, capacity two.
   logic [BW-1:0] q[$];
   logic [BW-1:0] shown = '0;
   int            stalls = 0;
   int            delivered = 0;

   logic [BW-1:0] w_obs;
   assign w_obs = {r_reg1_out, r_reg2_out, wr_reg_out, func3_out, func7_out, opcode_out,
                   immediate_data_out};

   function automatic logic [BW-1:0] cur_in();
      return {r_reg1, r_reg2, wr_reg, func3, func7, opcode, immediate_data};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      check("out_valid", 64'(out_valid), 64'(q.size() > 0));
      check("in_ready", 64'(in_ready), 64'(q.size() < 2));
      check("bundle", 64'(w_obs), 64'((q.size() > 0) ? q[0] : shown));
      check("stall_cnt", 64'(stall_cnt), 64'(stalls));
   endtask

   task automatic rand_bundle();
      r_reg1         = AW'($urandom);
      r_reg2         = AW'($urandom);
      wr_reg         = AW'($urandom);
      func3          = 3'($urandom);
      func7          = 7'($urandom);
      opcode         = 7'($urandom);
      immediate_data = W'($urandom);
   endtask

   // Inputs already driven: check current outputs, advance model, clock once.
   task automatic tick();
      bit iv, ov;
      check_model();
      iv = in_valid && (q.size() < 2);
      ov = (q.size() > 0) && out_ready;
      if ((q.size() > 0) && !out_ready && stalls < CMAX) stalls++;
      if (flush) begin
         q.delete();
      end else begin
         if (ov) begin
            void'(q.pop_front());
            delivered++;
         end
         if (iv) q.push_back(cur_in());
      end
      if (q.size() > 0) shown = q[0];
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      flush     = 1'b0;
      rst_n     = 1'b0;
      #13;
      rst_n = 1'b1;
      q.delete();
      shown  = '0;
      stalls = 0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state
      do_reset();
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_bundle", 64'(w_obs), 64'd0);
      check("rst_stall_cnt", 64'(stall_cnt), 64'd0);

      // Single bundle, one-cycle latency
      rand_bundle();
      opcode = 7'h33;
      immediate_data = 8'hA5;
      in_valid = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      check("lat_out_valid", 64'(out_valid), 64'd1);
      check("lat_opcode", 64'(opcode_out), 64'h33);
      check("lat_imm", 64'(immediate_data_out), 64'hA5);
      tick();
      tick();

      // Three bundles into a stalled consumer
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         rand_bundle();
         immediate_data = W'(i);
         while (!(q.size() < 2)) begin
            check("fill_in_ready_low", 64'(in_ready), 64'd0);
            check("fill_hold_imm", 64'(immediate_data_out), 64'h01);
            tick();
            if (i == 3 && stalls >= 3) out_ready = 1'b1;
         end
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      check("order_drained", 64'(out_valid), 64'd0);
      check("order_last_imm", 64'(immediate_data_out), 64'h03);

      // Streaming throughput
      in_valid = 1'b1;
      rand_bundle();
      tick();
      delivered = 0;
      for (int i = 0; i < 10; i++) begin
         rand_bundle();
         check("stream_in_ready", 64'(in_ready), 64'd1);
         tick();
      end
      check("stream_count", 64'(delivered), 64'd10);
      in_valid = 1'b0;
      tick();

      // Flush from FULL with a concurrent input
      out_ready = 1'b0;
      in_valid  = 1'b1;
      rand_bundle(); tick();
      rand_bundle(); tick();
      check("pre_flush_full", 64'(in_ready), 64'd0);
      flush = 1'b1;
      rand_bundle(); tick();
      flush = 1'b0;
      in_valid = 1'b0;
      check("flush_out_valid", 64'(out_valid), 64'd0);
      check("flush_in_ready", 64'(in_ready), 64'd1);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("flush_no_leak", 64'(out_valid), 64'd0);
         tick();
      end

      // Stall counter saturation
      do_reset();
      in_valid = 1'b1;
      rand_bundle();
      tick();
      in_valid = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      check("sat_cnt", 64'(stall_cnt), 64'd15);
      tick();
      check("sat_cnt_hold", 64'(stall_cnt), 64'd15);

      // Asynchronous reset between edges while FULL
      in_valid = 1'b1;
      rand_bundle(); tick();
      check("pre_async_full", 64'(in_ready), 64'd0);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", 64'(out_valid), 64'd0);
      check("arst_in_ready", 64'(in_ready), 64'd1);
      check("arst_stall_cnt", 64'(stall_cnt), 64'd0);
      check("arst_bundle", 64'(w_obs), 64'd0);
      q.delete();
      shown  = '0;
      stalls = 0;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Randomized traffic against the queue model
      for (int i = 0; i < 400; i++) begin
         in_valid  = 1'($urandom_range(0, 3) != 0);
         out_ready = 1'($urandom_range(0, 2) != 0);
         flush     = 1'($urandom_range(0, 15) == 0);
         rand_bundle();
         tick();
      end
      flush = 1'b0;
      in_valid = 1'b0;
      check_model();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
